// File: rtl/pc_seq_pkg.sv
// Shared encodings for the fetch-stage PC sequencer: FSM states and next-PC source selects.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_HOLD = 3'd1,
        SRC_BR   = 3'd2,
        SRC_JMP  = 3'd3,
        SRC_TRAP = 3'd4
    } pc_src_e;

    function automatic logic is_redirect(input pc_src_e src);
        return (src == SRC_BR) || (src == SRC_JMP) || (src == SRC_TRAP);
    endfunction

endpackage

// File: rtl/pc_step_adder.sv
// Sequential-step adder: pc + STEP modulo 2^WIDTH, with the carry out of the top bit.
module pc_step_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH:0] sum_ext;

    assign sum_ext = {1'b0, pc_i} + (WIDTH+1)'(STEP);
    assign sum_o   = sum_ext[WIDTH-1:0];
    assign carry_o = sum_ext[WIDTH];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: picks the next PC (step/branch/jump/trap/hold) and runs the BOOT/RUN/HALT FSM.
//   state   | meaning
//   ST_BOOT | first cycle after reset, no valid fetch, pc stays at RESET_VECTOR
//   ST_RUN  | fetching; pc advances or is redirected every cycle
//   ST_HALT | fetch stopped, pc held; only resume or trap leave
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = 1,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             trap,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             fetch_valid,
    output logic             flush,
    output logic             halted,
    output logic             wrapped
);

    seq_state_e       state_q, state_d;
    pc_src_e          src_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] step_sum;
    logic             step_carry;
    logic             flush_q, flush_d;
    logic             wrapped_q, wrapped_d;
    logic             fetch_valid_q;
    logic             halted_q;

    pc_step_adder #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step_adder (
        .pc_i    (pc_q),
        .sum_o   (step_sum),
        .carry_o (step_carry)
    );

    always_comb begin
        state_d = state_q;
        src_d   = SRC_HOLD;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (trap)                src_d = SRC_TRAP;
                else if (branch_taken)   src_d = SRC_BR;
                else if (jump)           src_d = SRC_JMP;
                else if (stall || halt)  src_d = SRC_HOLD;
                else                     src_d = SRC_SEQ;
                // trap suppresses halt; other redirects still land in HALT
                if (halt && !trap) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (trap) begin
                    src_d   = SRC_TRAP;
                    state_d = ST_RUN;
                end else if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        case (src_d)
            SRC_SEQ:  pc_d = step_sum;
            SRC_BR:   pc_d = branch_target;
            SRC_JMP:  pc_d = jump_target;
            SRC_TRAP: pc_d = TRAP_VECTOR;
            default:  pc_d = pc_q;
        endcase
        flush_d   = is_redirect(src_d);
        wrapped_d = wrapped_q | ((src_d == SRC_SEQ) & step_carry);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            flush_q       <= 1'b0;
            wrapped_q     <= 1'b0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            flush_q       <= flush_d;
            wrapped_q     <= wrapped_d;
            fetch_valid_q <= (state_d == ST_RUN);
            halted_q      <= (state_d == ST_HALT);
        end
    end

    assign pc          = pc_q;
    assign pc_plus     = step_sum;
    assign fetch_valid = fetch_valid_q;
    assign flush       = flush_q;
    assign halted      = halted_q;
    assign wrapped     = wrapped_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter sequencer for the fetch stage of the 5-stage pipeline.
- Each cycle it selects the next PC from: sequential increment by STEP, branch target, jump target, trap vector, or hold.
- Tracks a run/halt state machine and a sticky wrap-around flag.
- Outputs feed the instruction-memory address and the IF/ID pipeline register.

Parameters:
- WIDTH, 32, PC and target width in bits.
- STEP, 1, sequential increment amount (word addressing; 4 for byte addressing).
- RESET_VECTOR, 0, PC value loaded by reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold the PC (hazard unit).
- branch_taken  input  1  redirect to branch_target.
- branch_target  input  WIDTH  branch destination.
- jump  input  1  redirect to jump_target.
- jump_target  input  WIDTH  jump destination.
- trap  input  1  redirect to TRAP_VECTOR.
- halt  input  1  request halt.
- resume  input  1  leave the halt state.
- pc  output  WIDTH  current fetch address (registered).
- pc_plus  output  WIDTH  pc + STEP, combinational from pc (link value).
- fetch_valid  output  1  pc is a valid fetch this cycle.
- flush  output  1  one-cycle pulse after any redirect.
- halted  output  1  state machine is in HALT.
- wrapped  output  1  sticky: the sequential increment has overflowed.

Behaviour:
- Reset (async, any time, including mid-redirect): pc=RESET_VECTOR, state=BOOT, fetch_valid=0, flush=0, halted=0, wrapped=0.
- States: BOOT, RUN, HALT.
  - BOOT -> RUN unconditionally on the first clock edge after rst deasserts. pc is unchanged on that edge, so the first valid fetch is RESET_VECTOR.
  - In RUN, fetch_valid=1.
  - RUN -> HALT when halt=1 and trap=0. pc holds and fetch_valid=0 from the next cycle.
  - HALT -> RUN when resume=1. pc is unchanged and fetch resumes at the held pc.
  - In HALT, a trap forces a transition to RUN with pc=TRAP_VECTOR. All other inputs are ignored.
- Next-PC priority in RUN, highest first:
  1. trap -> TRAP_VECTOR
  2. branch_taken -> branch_target
  3. jump -> jump_target
  4. stall -> pc (hold)
  5. otherwise pc+STEP
- A redirect (trap/branch/jump) overrides stall in the same cycle.
- flush is registered: it is 1 in the cycle after any accepted redirect, otherwise 0. flush is not asserted for a hold or a sequential step.
- Latency: inputs sampled at edge N take effect on pc after edge N; pc_plus follows pc combinationally.
- Arithmetic: pc+STEP is computed modulo 2^WIDTH.
  - When a sequential step carries out of WIDTH bits, wrapped is set to 1 and stays set until reset.
  - Redirects never set wrapped.
  - pc_plus wraps silently.
- Simultaneous halt and redirect in RUN: the redirect is applied to pc and the state still moves to HALT, except that trap suppresses halt.
- Simultaneous halt and resume in HALT: resume wins.
- No X propagation: all registers are reset.

Decomposition:
- Package pc_seq_pkg holds:
  - state encoding constants: ST_BOOT=2'd0, ST_RUN=2'd1, ST_HALT=2'd2
  - next-PC source select constants: SRC_SEQ, SRC_HOLD, SRC_BR, SRC_JMP, SRC_TRAP
- Sub-module pc_step_adder (WIDTH, STEP): combinational sum plus carry-out. It is instantiated once; its output drives pc_plus and the SRC_SEQ path.

Test Plan:
- Reset, then idle for 4 cycles, STEP=1 -> pc: 0 (BOOT, fetch_valid=0), 0, 1, 2, 3 with fetch_valid=1; flush=0 throughout.
- At pc=5, stall for 2 cycles, then branch_taken with branch_target=0x40 while stall=1 -> pc holds 5 for 2 cycles, then becomes 0x40; flush=1 in the following cycle only; pc then steps to 0x41.
- trap, branch_taken and jump all asserted together (branch_target=0x10, jump_target=0x20) -> pc=0x100; one flush pulse.
- halt at pc=8 -> halted=1, fetch_valid=0, pc stays 8 for 5 cycles; resume -> RUN, pc=8 valid, then 9.
- WIDTH=8, STEP=4, jump to 0xFC -> next pcs 0x00, 0x04; wrapped=1 and stays 1 after a later branch to 0x10.
- Assert rst asynchronously mid-cycle during a jump with flush pending -> pc=RESET_VECTOR, flush=0, wrapped=0 immediately, without waiting for a clock edge; BOOT sequence repeats.
